// File: rtl/contador_programa.sv
// contador_programa: registered program counter with branch/JR selection, HALT and kernel save/restore.
module contador_programa #(
    parameter int                 LARGURA     = 32,
    parameter logic [LARGURA-1:0] PC_INICIAL  = '0,
    parameter logic [LARGURA-1:0] BASE_KERNEL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
    input  logic [LARGURA-1:0] Endereco_Desvio,
    input  logic [LARGURA-1:0] Registrador_JR,
    input  logic               Habilita,
    input  logic               Continuar,
    output logic [LARGURA-1:0] PC,
    output logic [LARGURA-1:0] PC_Mais_Um,
    output logic [LARGURA-1:0] PC_Salvo,
    output logic               Parado
);
    localparam logic [5:0] OP_HLT     = 6'b001100;
    localparam logic [5:0] OP_SWAP    = 6'b100001;
    localparam logic [5:0] OP_RETORNO = 6'b100010;
    localparam logic [5:0] OP_JR      = 6'b010011;

    typedef enum logic {EXEC, PARADO} estado_t;

    estado_t            estado, estado_prox;
    logic [LARGURA-1:0] pc_prox, salvo_prox;
    logic               avanca;

    assign PC_Mais_Um = PC + 1'b1;
    assign Parado     = (estado == PARADO);
    assign avanca     = (estado == EXEC) && Habilita;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= EXEC;
            PC       <= PC_INICIAL;
            PC_Salvo <= '0;
        end else begin
            estado   <= estado_prox;
            PC       <= pc_prox;
            PC_Salvo <= salvo_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        if (avanca && Opcode == OP_HLT)
            estado_prox = PARADO;
        else if (estado == PARADO && Continuar)
            estado_prox = EXEC;
    end

    // In PARADO only Continuar moves the PC; everything else holds.
    always_comb begin
        pc_prox    = PC;
        salvo_prox = PC_Salvo;
        if (estado == PARADO)
            pc_prox = Continuar ? PC_Mais_Um : PC;
        else if (avanca) begin
            if (Opcode == OP_HLT)
                pc_prox = PC;
            else if (Opcode == OP_SWAP) begin
                pc_prox    = BASE_KERNEL;
                salvo_prox = PC_Mais_Um;
            end else if (Opcode == OP_RETORNO)
                pc_prox = PC_Salvo;
            else if (Zero)
                pc_prox = (Opcode == OP_JR) ? Registrador_JR : Endereco_Desvio;
            else
                pc_prox = PC_Mais_Um;
        end
    end
endmodule
